tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer_if.sv | 23 ++
 rtl/tone_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Pattern-load handshake between a pattern source and the tone sequencer.
// The source offers one 5-bit entry per accepted cycle (bit4 = rest,
// bits3:0 = pitch code) and may empty the stored pattern with load_clear.
interface tone_sequencer_if;
   logic       load_valid;
   logic [4:0] load_data;
   logic       load_ready;
   logic       load_clear;

   modport master (
      output load_valid,
      output load_data,
      output load_clear,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_clear,
      output load_ready
   );
endinterface

// File: rtl/tone_sequencer.sv
// Tone sequencer: stores up to STEPS note entries and plays them back one
// step every tempo ticks, driving pitch, gate and phase-reset strobes for a
// downstream waveform generator. Gate drops on the last tick of each step to
// articulate repeated notes; a rest entry keeps the gate low for its step.
module tone_sequencer #(
   parameter int STEPS   = 8,
   parameter int TEMPO_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   tone_sequencer_if.slave            ld,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop,
   input  logic [TEMPO_W-1:0]         tempo,
   output logic [3:0]                 freq_sel,
   output logic                       gate,
   output logic                       note_start,
   output logic [$clog2(STEPS)-1:0]   step_idx,
   output logic                       busy,
   output logic                       done
);

   localparam int IW = $clog2(STEPS);
   localparam int LW = $clog2(STEPS + 1);
   localparam logic [TEMPO_W-1:0] ONE_T = TEMPO_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t             state_q, state_n;
   logic [LW-1:0]      len_q, len_n;
   logic [IW-1:0]      step_q, step_n;
   logic [TEMPO_W-1:0] tick_q, tick_n;
   logic [TEMPO_W-1:0] te_q, te_n;
   logic               done_n;

   logic [3:0]         freq_q;
   logic               gate_q;
   logic               note_q;
   logic               done_q;

   logic [4:0]         mem [STEPS];

   logic               accept;
   logic               last_tick;
   logic               last_step;
   logic               start_ok;
   logic [4:0]         entry_n;
   logic               gate_n;
   logic               note_n;

   // A tempo of zero would never terminate a step; treat it as one tick.
   function automatic logic [TEMPO_W-1:0] eff_tempo(input logic [TEMPO_W-1:0] t);
      return (t == '0) ? ONE_T : t;
   endfunction

   assign ld.load_ready = (state_q == IDLE) && (len_q < LW'(STEPS));
   assign accept        = ld.load_ready && ld.load_valid && !ld.load_clear;
   assign last_tick     = (tick_q == te_q - ONE_T);
   assign last_step     = ((LW'(step_q) + LW'(1)) == len_q);
   // Stop wins over start; a same-cycle clear leaves nothing to play.
   assign start_ok      = start && !stop && ena && !ld.load_clear && (len_q != '0);

   // Next-state logic for playback position, pattern length and completion.
   always_comb begin
      state_n = state_q;
      len_n   = len_q;
      step_n  = step_q;
      tick_n  = tick_q;
      te_n    = te_q;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld.load_clear) begin
               len_n = '0;
            end else if (accept) begin
               len_n = len_q + LW'(1);
            end
            if (start_ok) begin
               state_n = PLAY;
               step_n  = '0;
               tick_n  = '0;
               te_n    = eff_tempo(tempo);
            end
         end
         PLAY: begin
            if (stop) begin
               state_n = IDLE;
               step_n  = '0;
               tick_n  = '0;
            end else if (ena) begin
               if (last_tick) begin
                  tick_n = '0;
                  if (last_step) begin
                     step_n = '0;
                     if (!loop) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end
                  end else begin
                     step_n = step_q + IW'(1);
                  end
               end else begin
                  tick_n = tick_q + ONE_T;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output values for the upcoming cycle, derived from the next position so
   // the registered outputs line up with the registered state.
   assign entry_n = mem[step_n];
   assign gate_n  = (state_n == PLAY) && !entry_n[4] &&
                    ((te_n == ONE_T) || (tick_n != te_n - ONE_T));
   assign note_n  = (state_n == PLAY) && !entry_n[4] && (tick_n == '0);

   // Sequencer FSM state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         step_q  <= '0;
         tick_q  <= '0;
         te_q    <= ONE_T;
         freq_q  <= 4'd0;
         gate_q  <= 1'b0;
         note_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         len_q   <= len_n;
         step_q  <= step_n;
         tick_q  <= tick_n;
         te_q    <= te_n;
         freq_q  <= (state_n == PLAY) ? entry_n[3:0] : 4'd0;
         gate_q  <= gate_n;
         note_q  <= note_n;
         done_q  <= done_n;
      end
   end

   // Pattern storage; contents are left as-is by reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[len_q[IW-1:0]] <= ld.load_data;
      end
   end

   // Disable silences the note strobes immediately, not one cycle later.
   assign freq_sel   = freq_q;
   assign gate       = gate_q & ena;
   assign note_start = note_q & ena;
   assign done       = done_q & ena;
   assign busy       = (state_q == PLAY);
   assign step_idx   = step_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a behavioural pattern-player model
// is checked against the DUT every cycle, with directed scenarios pinned by
// hand-computed values and a randomized stress phase.
module tb_tone_sequencer;
   localparam int STEPS   = 8;
   localparam int TEMPO_W = 16;

   logic               clk   = 1'b0;
   logic               rst_n = 1'b0;
   logic               ena   = 1'b0;
   logic               start = 1'b0;
   logic               stop  = 1'b0;
   logic               loop  = 1'b0;
   logic [TEMPO_W-1:0] tempo = '0;
   logic [3:0]         freq_sel;
   logic               gate, note_start, busy, done;
   logic [2:0]         step_idx;

   tone_sequencer_if ld();

   tone_sequencer #(.STEPS(STEPS), .TEMPO_W(TEMPO_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .ld         (ld.slave),
      .start      (start),
      .stop       (stop),
      .loop       (loop),
      .tempo      (tempo),
      .freq_sel   (freq_sel),
      .gate       (gate),
      .note_start (note_start),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // model state
   logic [4:0] m_pat [STEPS];
   int         m_len, m_step, m_tick, m_te;
   bit         m_play, m_done;

   int n_cmp, n_fail;
   int s_busy, s_step, s_freq, s_gate, s_note, s_done, s_ready;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_len = 0; m_step = 0; m_tick = 0; m_te = 1; m_play = 0; m_done = 0;
   endtask

   // One clock edge of the pattern player, from the behavioural rules.
   task automatic model_update();
      bit start_ok;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (!m_play) begin
         start_ok = start && !stop && ena && !ld.load_clear && (m_len > 0);
         if (ld.load_clear) m_len = 0;
         else if (ld.load_valid && m_len < STEPS) begin
            m_pat[m_len] = ld.load_data;
            m_len++;
         end
         if (start_ok) begin
            m_play = 1; m_step = 0; m_tick = 0;
            m_te = (tempo == 0) ? 1 : int'(tempo);
         end
      end else if (stop) begin
         m_play = 0; m_step = 0; m_tick = 0;
      end else if (ena) begin
         m_tick++;
         if (m_tick == m_te) begin
            m_tick = 0;
            m_step++;
            if (m_step == m_len) begin
               m_step = 0;
               if (!loop) begin
                  m_play = 0;
                  m_done = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      bit rest;
      int e_gate, e_note, e_freq;
      rest   = m_play ? m_pat[m_step][4] : 1'b1;
      e_freq = m_play ? int'(m_pat[m_step][3:0]) : 0;
      e_gate = (ena && m_play && !rest && (m_te == 1 || m_tick != m_te - 1)) ? 1 : 0;
      e_note = (ena && m_play && !rest && m_tick == 0) ? 1 : 0;
      chk("busy",       busy,          m_play);
      chk("step_idx",   step_idx,      m_step);
      chk("freq_sel",   freq_sel,      e_freq);
      chk("gate",       gate,          e_gate);
      chk("note_start", note_start,    e_note);
      chk("done",       done,          (ena && m_done) ? 1 : 0);
      chk("load_ready", ld.load_ready, (!m_play && m_len < STEPS) ? 1 : 0);
   endtask

   // Called with inputs set just after a falling edge; returns at the next one.
   task automatic tick_cycle();
      #1;
      check_all();
      s_busy = busy; s_step = step_idx; s_freq = freq_sel; s_gate = gate;
      s_note = note_start; s_done = done; s_ready = ld.load_ready;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic load_entry(input logic [4:0] d);
      ld.load_valid = 1'b1;
      ld.load_data  = d;
      tick_cycle();
      ld.load_valid = 1'b0;
   endtask

   int gsum, nsum, dsum, f0, f4, f8, held, frozen_step;

   initial begin
      ld.load_valid = 1'b0;
      ld.load_data  = '0;
      ld.load_clear = 1'b0;
      n_cmp = 0;
      n_fail = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy",  busy, 0);
      chk("rst_gate",  gate, 0);
      chk("rst_freq",  freq_sel, 0);
      chk("rst_step",  step_idx, 0);
      chk("rst_done",  done, 0);
      chk("rst_ready", ld.load_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick_cycle();

      // three-entry one-shot pattern at tempo 4
      load_entry(5'd5);
      load_entry(5'd9);
      load_entry(5'h10);
      tempo = 4; loop = 0; start = 1;
      tick_cycle();
      start = 0;
      gsum = 0; nsum = 0; dsum = 0; f0 = -1; f4 = -1; f8 = -1;
      for (int k = 0; k < 12; k++) begin
         tick_cycle();
         gsum += s_gate; nsum += s_note; dsum += s_done;
         if (k == 0) f0 = s_freq;
         if (k == 4) f4 = s_freq;
         if (k == 8) f8 = s_freq;
      end
      chk("oneshot_gate_cycles", gsum, 6);
      chk("oneshot_note_pulses", nsum, 2);
      chk("oneshot_freq_step0", f0, 5);
      chk("oneshot_freq_step1", f4, 9);
      chk("oneshot_freq_step2", f8, 0);
      chk("oneshot_no_early_done", dsum, 0);
      tick_cycle();
      chk("oneshot_done", s_done, 1);
      chk("oneshot_busy_after", s_busy, 0);
      tick_cycle();
      chk("oneshot_done_once", s_done, 0);

      // fill to capacity, overflow attempt, clear
      ld.load_clear = 1; tick_cycle(); ld.load_clear = 0;
      for (int i = 0; i < STEPS; i++) load_entry(5'(i + 1));
      tick_cycle();
      chk("full_ready_low", s_ready, 0);
      load_entry(5'd15);
      ld.load_clear = 1; tick_cycle(); ld.load_clear = 0;
      tick_cycle();
      chk("clear_ready_high", s_ready, 1);
      start = 1; tick_cycle(); start = 0;
      tick_cycle();
      chk("empty_start_ignored", s_busy, 0);

      // two entries, looping, tempo 0
      load_entry(5'd3);
      load_entry(5'd7);
      loop = 1; tempo = 0; start = 1;
      tick_cycle();
      start = 0;
      for (int k = 0; k < 6; k++) begin
         tick_cycle();
         chk("fast_loop_step", s_step, k % 2);
         chk("fast_loop_gate", s_gate, 1);
         chk("fast_loop_note", s_note, 1);
         chk("fast_loop_done", s_done, 0);
      end
      stop = 1; tick_cycle(); stop = 0;
      tick_cycle();

      // stop together with start mid step 1
      loop = 0; tempo = 4; start = 1;
      tick_cycle();
      start = 0;
      for (int k = 0; k < 5; k++) tick_cycle();
      chk("stop_pre_step", s_step, 1);
      stop = 1; start = 1;
      tick_cycle();
      stop = 0; start = 0;
      tick_cycle();
      chk("stop_busy", s_busy, 0);
      chk("stop_freq", s_freq, 0);
      chk("stop_gate", s_gate, 0);
      chk("stop_done", s_done, 0);

      // disable for five cycles mid step 1 (tick 2 of 6)
      loop = 1; tempo = 6; start = 1;
      tick_cycle();
      start = 0;
      for (int k = 0; k < 8; k++) tick_cycle();
      ena = 0;
      frozen_step = -1;
      for (int k = 0; k < 5; k++) begin
         tick_cycle();
         if (k == 0) frozen_step = s_step;
         chk("freeze_step", s_step, 1);
         chk("freeze_gate", s_gate, 0);
      end
      ena = 1;
      held = 0;
      for (int k = 0; k < 6; k++) begin
         tick_cycle();
         if (s_step == frozen_step && held == k) held++;
      end
      chk("resume_remaining_ticks", held, 4);
      stop = 1; tick_cycle(); stop = 0;

      // asynchronous reset between edges while playing
      loop = 0; tempo = 3; start = 1;
      tick_cycle();
      start = 0;
      tick_cycle();
      tick_cycle();
      #3;
      rst_n = 0;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_gate", gate, 0);
      chk("areset_note", note_start, 0);
      chk("areset_freq", freq_sel, 0);
      chk("areset_step", step_idx, 0);
      chk("areset_done", done, 0);
      chk("areset_ready", ld.load_ready, 1);
      model_reset();
      @(posedge clk);
      model_update();
      @(negedge clk);
      rst_n = 1;
      start = 1; tick_cycle(); start = 0;
      tick_cycle();
      chk("areset_start_ignored", s_busy, 0);

      // randomized stress against the model
      for (int c = 0; c < 3000; c++) begin
         ld.load_valid = ($urandom_range(0, 99) < 35);
         ld.load_data  = 5'($urandom);
         ld.load_clear = ($urandom_range(0, 99) < 3);
         start         = ($urandom_range(0, 99) < 12);
         stop          = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 5) loop = ~loop;
         if ($urandom_range(0, 99) < 5) tempo = TEMPO_W'($urandom_range(0, 5));
         ena           = ($urandom_range(0, 99) < 85);
         tick_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
